// File: rtl/debug_regfile_dumper_if.sv
// Register-file debug port plus byte stream towards the UART transmitter.
// The dumper drives the master side; the register file and transmitter sit on the slave side.
interface debug_regfile_dumper_if #(
  parameter int REG_AW = 5
);
  logic              debug_on;
  logic              stop_debug;
  logic [REG_AW-1:0] debug_read_reg;
  logic [31:0]       reg_debug_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output debug_on, stop_debug, debug_read_reg, tx_data, tx_valid,
    input  reg_debug_data, tx_ready
  );

  modport slave (
    input  debug_on, stop_debug, debug_read_reg, tx_data, tx_valid,
    output reg_debug_data, tx_ready
  );
endinterface

// File: rtl/debug_regfile_dumper.sv
// Freezes the pipeline, reads every register through the debug port and streams
// each 32-bit word MSB first as four bytes on a valid/ready byte interface.
module debug_regfile_dumper #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int RD_LAT   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  debug_regfile_dumper_if.master dbg
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WCW-1:0]    WAIT_LAST = WCW'(RD_LAT - 1);
  localparam logic [REG_AW-1:0] ADDR_LAST = REG_AW'(NUM_REGS - 1);

  state_t            state, stateNext;
  logic [REG_AW-1:0] addrReg, addrNext;
  logic [31:0]       shiftReg, shiftNext;
  logic [1:0]        byteIdx, byteIdxNext;
  logic [WCW-1:0]    waitCnt, waitCntNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addrReg  <= '0;
      shiftReg <= '0;
      byteIdx  <= '0;
      waitCnt  <= '0;
    end else begin
      state    <= stateNext;
      addrReg  <= addrNext;
      shiftReg <= shiftNext;
      byteIdx  <= byteIdxNext;
      waitCnt  <= waitCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    addrNext    = addrReg;
    shiftNext   = shiftReg;
    byteIdxNext = byteIdx;
    waitCntNext = waitCnt;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext   = WAIT;
          addrNext    = '0;
          waitCntNext = '0;
        end
      end
      WAIT: begin
        // Address has been stable on debug_read_reg since entering WAIT.
        if (waitCnt == WAIT_LAST) begin
          waitCntNext = '0;
          stateNext   = LOAD;
        end else begin
          waitCntNext = waitCnt + WCW'(1);
        end
      end
      LOAD: begin
        shiftNext   = dbg.reg_debug_data;
        byteIdxNext = '0;
        stateNext   = SEND;
      end
      SEND: begin
        if (dbg.tx_ready) begin
          shiftNext   = {shiftReg[23:0], 8'h00};
          byteIdxNext = byteIdx + 2'd1;
          if (byteIdx == 2'd3) begin
            // The last register keeps its address so no wrap ever reaches the port.
            if (addrReg == ADDR_LAST) begin
              stateNext = DONE;
            end else begin
              addrNext  = addrReg + REG_AW'(1);
              stateNext = WAIT;
            end
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Freeze outputs decode straight from the state so an async reset drops them at once.
  assign busy               = (state != IDLE);
  assign done               = (state == DONE);
  assign dbg.debug_on       = busy;
  assign dbg.stop_debug     = busy;
  assign dbg.debug_read_reg = addrReg;
  assign dbg.tx_valid       = (state == SEND);
  assign dbg.tx_data        = shiftReg[31:24];

endmodule

// File: tb/tb_debug_regfile_dumper.sv
// Scoreboard bench: stimulus queues expected bytes and checks, one negedge monitor compares.
module tb_debug_regfile_dumper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, startA, startB;
  logic busyA, doneA, busyB, doneB;

  debug_regfile_dumper_if #(.REG_AW(5)) ifA ();
  debug_regfile_dumper_if #(.REG_AW(5)) ifB ();

  debug_regfile_dumper #(.NUM_REGS(32), .REG_AW(5), .RD_LAT(1)) dutA (
    .clk(clk), .rst(rst), .start(startA), .busy(busyA), .done(doneA), .dbg(ifA.master)
  );
  debug_regfile_dumper #(.NUM_REGS(32), .REG_AW(5), .RD_LAT(3)) dutB (
    .clk(clk), .rst(rst), .start(startB), .busy(busyB), .done(doneB), .dbg(ifB.master)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file models: one-cycle read for A, three-cycle read for B.
  logic [31:0] regsA [32];
  logic [31:0] regsB [32];
  logic [31:0] rdA;
  logic [31:0] pipeB [3];
  always @(posedge clk) rdA <= regsA[ifA.debug_read_reg];
  assign ifA.reg_debug_data = rdA;
  always @(posedge clk) begin
    pipeB[0] <= regsB[ifB.debug_read_reg];
    pipeB[1] <= pipeB[0];
    pipeB[2] <= pipeB[1];
  end
  assign ifB.reg_debug_data = pipeB[2];

  bit readyToggleA = 1'b0;
  bit togA = 1'b1;
  always @(posedge clk) begin
    #1;
    ifA.tx_ready = readyToggleA ? togA : 1'b1;
    togA = ~togA;
  end

  logic [7:0]  qA [$];
  logic [7:0]  qB [$];
  string       chkName [$];
  logic [31:0] chkAct [$];
  logic [31:0] chkExp [$];

  int total = 0, bad = 0;
  int bytesA = 0, bytesB = 0, doneCntA = 0, doneCntB = 0, doneCycA = 0, doneCycB = 0;
  bit holdA = 1'b0;
  logic [7:0] holdDataA;

  always @(negedge clk) begin
    string nm;
    logic [31:0] a, e;
    logic [7:0] eb;
    while (chkName.size() > 0) begin
      nm = chkName.pop_front();
      a  = chkAct.pop_front();
      e  = chkExp.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", nm, a, e);
      end
    end
    if (holdA) begin
      total++;
      if ({ifA.tx_valid, ifA.tx_data} !== {1'b1, holdDataA}) begin
        bad++;
        $display("FAIL A hold: got valid=%b data=%h want valid=1 data=%h", ifA.tx_valid, ifA.tx_data, holdDataA);
      end
    end
    if (ifA.tx_valid === 1'b1 && ifA.tx_ready === 1'b1) begin
      total++;
      bytesA++;
      holdA = 1'b0;
      if (qA.size() == 0) begin
        bad++;
        $display("FAIL A byte: got %h want none", ifA.tx_data);
      end else begin
        eb = qA.pop_front();
        if (ifA.tx_data !== eb) begin
          bad++;
          $display("FAIL A byte %0d: got %h want %h", bytesA - 1, ifA.tx_data, eb);
        end
      end
    end else if (ifA.tx_valid === 1'b1) begin
      holdA = 1'b1;
      holdDataA = ifA.tx_data;
    end else begin
      holdA = 1'b0;
    end
    if (ifB.tx_valid === 1'b1 && ifB.tx_ready === 1'b1) begin
      total++;
      bytesB++;
      if (qB.size() == 0) begin
        bad++;
        $display("FAIL B byte: got %h want none", ifB.tx_data);
      end else begin
        eb = qB.pop_front();
        if (ifB.tx_data !== eb) begin
          bad++;
          $display("FAIL B byte %0d: got %h want %h", bytesB - 1, ifB.tx_data, eb);
        end
      end
    end
    if (doneA === 1'b1) begin
      doneCntA++;
      doneCycA = cyc;
    end
    if (doneB === 1'b1) begin
      doneCntB++;
      doneCycB = cyc;
    end
  end

  task automatic push(input string nm, input logic [31:0] a, input logic [31:0] e);
    chkName.push_back(nm);
    chkAct.push_back(a);
    chkExp.push_back(e);
  endtask

  // Expected stream: words in address order, each MSB first.
  task automatic pushDump(input bit which, input int nBytes);
    logic [31:0] w;
    for (int b = 0; b < nBytes; b++) begin
      w = which ? regsB[b / 4] : regsA[b / 4];
      if (which) qB.push_back(w[31 - 8 * (b % 4) -: 8]);
      else       qA.push_back(w[31 - 8 * (b % 4) -: 8]);
    end
  endtask

  task automatic pulseStart(input bit which, output int c);
    @(posedge clk);
    #1;
    if (which) startB = 1'b1;
    else       startA = 1'b1;
    c = cyc;
    @(posedge clk);
    #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic waitDone(input bit which, input int base, input int budget);
    int n = 0;
    while ((which ? doneCntB : doneCntA) == base && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    push(which ? "B done seen" : "A done seen", 32'((which ? doneCntB : doneCntA) != base), 32'd1);
  endtask

  task automatic waitAddr(input logic [4:0] addr, input bit needValid, output bit hit);
    int n = 0;
    hit = 1'b0;
    while (!hit && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
      hit = (ifA.debug_read_reg == addr) && (!needValid || ifA.tx_valid);
    end
  endtask

  initial begin
    int s, bA, dA;
    bit hit;
    rst = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    ifB.tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      regsA[i] = 32'h1000_0000 + 32'(i);
      regsB[i] = 32'h0BAD_0000 + 32'(i) * 32'h0000_0101;
    end
    repeat (3) @(negedge clk);
    #1;
    push("A reset outputs", 32'({ifA.debug_on, ifA.stop_debug, busyA, doneA, ifA.tx_valid}), 32'd0);
    push("A reset addr", 32'(ifA.debug_read_reg), 32'd0);
    push("B reset outputs", 32'({ifB.debug_on, ifB.stop_debug, busyB, doneB, ifB.tx_valid}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full dump, ready always high, second start at R10 must be ignored.
    bA = bytesA; dA = doneCntA;
    pushDump(1'b0, 128);
    pulseStart(1'b0, s);
    waitAddr(5'd10, 1'b0, hit);
    push("A reached R10", 32'(hit), 32'd1);
    push("A freeze while dumping", 32'({ifA.debug_on, ifA.stop_debug, busyA}), 32'h7);
    @(posedge clk);
    #1;
    startA = 1'b1;
    @(posedge clk);
    #1;
    startA = 1'b0;
    waitDone(1'b0, dA, 400);
    push("A cycles start to done", 32'(doneCycA - s + 1), 32'd194);
    push("A freeze during done", 32'({ifA.debug_on, ifA.stop_debug, busyA}), 32'h7);
    repeat (20) @(negedge clk);
    #1;
    push("A done pulses", 32'(doneCntA - dA), 32'd1);
    push("A bytes per dump", 32'(bytesA - bA), 32'd128);
    push("A idle after done", 32'({ifA.debug_on, ifA.stop_debug, busyA, doneA}), 32'd0);

    // Toggling ready, R5 = DEADBEEF, R3 source changes while its word is being sent.
    regsA[5] = 32'hDEAD_BEEF;
    readyToggleA = 1'b1;
    bA = bytesA; dA = doneCntA;
    pushDump(1'b0, 128);
    pulseStart(1'b0, s);
    waitAddr(5'd3, 1'b1, hit);
    push("A reached R3 send", 32'(hit), 32'd1);
    regsA[3] = 32'hCAFE_F00D;
    waitDone(1'b0, dA, 1500);
    @(negedge clk);
    readyToggleA = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    push("A toggle bytes", 32'(bytesA - bA), 32'd128);
    push("A toggle done pulses", 32'(doneCntA - dA), 32'd1);

    // Reset during R7 byte 2, then a clean restart from R0.
    bA = bytesA;
    pushDump(1'b0, 30);
    pulseStart(1'b0, s);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (bytesA - bA < 30 && n < 400);
    end
    @(posedge clk);
    #1;
    push("A pre-reset addr", 32'(ifA.debug_read_reg), 32'd7);
    push("A pre-reset byte", 32'({ifA.tx_valid, ifA.tx_data}), 32'h100);
    rst = 1'b1;
    #1;
    push("A reset mid-dump", 32'({ifA.tx_valid, ifA.debug_on, ifA.stop_debug, busyA, doneA}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    push("A bytes before reset", 32'(bytesA - bA), 32'd30);
    push("A idle after reset", 32'({busyA, 3'(ifA.debug_read_reg)}), 32'd0);
    bA = bytesA; dA = doneCntA;
    pushDump(1'b0, 128);
    pulseStart(1'b0, s);
    waitDone(1'b0, dA, 400);
    push("A restart cycles", 32'(doneCycA - s + 1), 32'd194);
    repeat (3) @(negedge clk);
    #1;
    push("A restart bytes", 32'(bytesA - bA), 32'd128);

    // Three-cycle read latency.
    pushDump(1'b1, 128);
    pulseStart(1'b1, s);
    waitDone(1'b1, 0, 600);
    push("B cycles start to done", 32'(doneCycB - s + 1), 32'd258);
    repeat (3) @(negedge clk);
    #1;
    push("B bytes", 32'(bytesB), 32'd128);
    push("B done pulses", 32'(doneCntB), 32'd1);
    push("A queue drained", 32'(qA.size()), 32'd0);
    push("B queue drained", 32'(qB.size()), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
